// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: bundles the CPU port, the DMA/loader port and the
// shared single-port memory bus that the arbiter sits between.
//   cpu_* / dma_* : request/acknowledge handshakes with payload and read data
//   mem_*         : memory enable, write enable, address, data in/out
//   grant         : current owner (00 none, 01 CPU, 10 DMA)
// slave  : the arbiter's view (drives acks, rdata, mem_*, grant)
// master : the requesters' and memory's view
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_ack;
  logic              cpu_stall;

  logic              dma_req;
  logic              dma_we;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic [DATA_W-1:0] dma_rdata;
  logic              dma_ack;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic [1:0]        grant;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    input  mem_rdata,
    output cpu_rdata, cpu_ack, cpu_stall,
    output dma_rdata, dma_ack,
    output mem_en, mem_we, mem_addr, mem_wdata,
    output grant
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output dma_req, dma_we, dma_addr, dma_wdata,
    output mem_rdata,
    input  cpu_rdata, cpu_ack, cpu_stall,
    input  dma_rdata, dma_ack,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    input  grant
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between the CPU datapath
// and a DMA/loader port. Each access is IDLE -> WAIT (WAIT_STATES+1 cycles)
// -> DONE (one-cycle ack). Ties are broken round-robin against the last
// owner. cpu_stall holds the control unit until the CPU access completes.
// Ports:
//   clock : system clock, rising edge
//   reset : synchronous active-low reset
//   bus   : mem_port_arbiter_if.slave (CPU, DMA and memory signals)
module mem_port_arbiter #(
  parameter int ADDR_W      = 64,
  parameter int DATA_W      = 64,
  parameter int WAIT_STATES = 2
) (
  input logic               clock,
  input logic               reset,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  localparam logic [3:0] CNT_INIT = 4'(WAIT_STATES);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              last_dma_q, last_dma_d;   // 1: DMA was granted last
  logic              owner_dma_q, owner_dma_d; // owner of the current access
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] dma_rdata_q, dma_rdata_d;
  logic              pick_dma;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      last_dma_q  <= 1'b1;
      owner_dma_q <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_dma_q  <= last_dma_d;
      owner_dma_q <= owner_dma_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      dma_rdata_q <= dma_rdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_dma_d  = last_dma_q;
    owner_dma_d = owner_dma_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cpu_rdata_d = cpu_rdata_q;
    dma_rdata_d = dma_rdata_q;
    pick_dma    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.cpu_req || bus.dma_req) begin
          // DMA wins when alone, or on a tie when the CPU was served last.
          pick_dma    = bus.dma_req && (!bus.cpu_req || !last_dma_q);
          owner_dma_d = pick_dma;
          last_dma_d  = pick_dma;
          we_d        = pick_dma ? bus.dma_we    : bus.cpu_we;
          addr_d      = pick_dma ? bus.dma_addr  : bus.cpu_addr;
          wdata_d     = pick_dma ? bus.dma_wdata : bus.cpu_wdata;
          cnt_d       = CNT_INIT;
          state_d     = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          // Memory read data is valid in the last WAIT cycle.
          if (!we_q) begin
            if (owner_dma_q) dma_rdata_d = bus.mem_rdata;
            else             cpu_rdata_d = bus.mem_rdata;
          end
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.mem_en    = (state_q == S_WAIT);
  assign bus.mem_we    = (state_q == S_WAIT) && we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.grant     = (state_q == S_IDLE) ? 2'b00 :
                         (owner_dma_q ? 2'b10 : 2'b01);
  assign bus.cpu_ack   = (state_q == S_DONE) && !owner_dma_q;
  assign bus.dma_ack   = (state_q == S_DONE) &&  owner_dma_q;
  assign bus.cpu_stall = bus.cpu_req && !bus.cpu_ack;
  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.dma_rdata = dma_rdata_q;

endmodule
